// File: rtl/alu_pkg.sv
// Shared types and Gselect opcode constants for the ALU issue/writeback block.
package alu_pkg;

    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Gselect encoding {S2,S1,S0,Cin} understood by the external ALU
    localparam logic [3:0] GSEL_INC = 4'b0001;
    localparam logic [3:0] GSEL_ADD = 4'b0010;
    localparam logic [3:0] GSEL_SUB = 4'b0101;
    localparam logic [3:0] GSEL_AND = 4'b1000;
    localparam logic [3:0] GSEL_OR  = 4'b1010;
    localparam logic [3:0] GSEL_XOR = 4'b1100;
    localparam logic [3:0] GSEL_NOT = 4'b1110;

endpackage

// File: rtl/fu_regfile.sv
// Register file: two asynchronous operand read ports, an asynchronous debug tap,
// one synchronous write port. Register 0 is hardwired to zero.
module fu_regfile
    import alu_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [W-1:0]      ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [W-1:0]      rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [W-1:0]      dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [W-1:0]      wdata
);

    logic [NREG-1:0][W-1:0] regs_q;
    logic [NREG-1:0][W-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-to-read bypass: a write becomes visible the cycle after its edge
    assign ra_data  = regs_q[ra_addr];
    assign rb_data  = regs_q[rb_addr];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Issues one register/immediate op to an external ALU, captures its result and
// flags, then writes back: a fixed three-cycle IDLE -> EXEC -> WB sequence.
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_AW-1:0] req_sa,
    input  logic [REG_AW-1:0] req_sb,
    input  logic [REG_AW-1:0] req_dst,
    input  logic [3:0]        req_gsel,
    input  logic              req_use_const,
    input  logic [W-1:0]      req_const,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_gsel,
    input  logic [W-1:0]      alu_g,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_dst,
    output logic [W-1:0]      wb_data,
    output logic [3:0]        status,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [W-1:0]      dbg_data
);

    state_t              state_q, state_d;
    logic [W-1:0]        alu_a_q, alu_a_d;
    logic [W-1:0]        alu_b_q, alu_b_d;
    logic [3:0]          alu_gsel_q, alu_gsel_d;
    logic [REG_AW-1:0]   dst_q, dst_d;
    logic [W-1:0]        res_q, res_d;
    logic [3:0]          flags_q, flags_d;
    logic [3:0]          status_q, status_d;
    logic [W-1:0]        rf_a_data, rf_b_data;
    logic                accept;
    logic                rf_we;

    fu_regfile #(.W(W), .NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (req_sa),
        .ra_data  (rf_a_data),
        .rb_addr  (req_sb),
        .rb_data  (rf_b_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (dst_q),
        .wdata    (res_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        wb_valid  = (state_q == ST_WB);
        rf_we     = (state_q == ST_WB);
    end

    assign accept = req_valid && req_ready;

    // Operands are latched only on accept and held for the rest of the op
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_gsel_d = alu_gsel_q;
        dst_d      = dst_q;
        res_d      = res_q;
        flags_d    = flags_q;
        status_d   = status_q;
        if (accept) begin
            alu_a_d    = rf_a_data;
            alu_b_d    = req_use_const ? req_const : rf_b_data;
            alu_gsel_d = req_gsel;
            dst_d      = req_dst;
        end
        if (state_q == ST_EXEC) begin
            res_d   = alu_g;
            flags_d = {alu_z, alu_n, alu_c, alu_v};
        end
        if (state_q == ST_WB) begin
            status_d = flags_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_gsel_q <= '0;
            dst_q      <= '0;
            res_q      <= '0;
            flags_q    <= '0;
            status_q   <= '0;
        end else begin
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_gsel_q <= alu_gsel_d;
            dst_q      <= dst_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
            status_q   <= status_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_gsel = alu_gsel_q;
    assign wb_dst   = dst_q;
    assign wb_data  = res_q;
    assign status   = status_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Self-checking bench for alu_issue_wb: a behavioural ALU drives the result
// inputs and a register-array model predicts every writeback.
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_sa, req_sb, req_dst;
    logic [3:0]  req_gsel;
    logic        req_use_const;
    logic [31:0] req_const;
    logic [31:0] alu_a, alu_b, alu_g;
    logic [3:0]  alu_gsel;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic        wb_valid;
    logic [2:0]  wb_dst;
    logic [31:0] wb_data;
    logic [3:0]  status;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_r [8];

    always #5 clk = ~clk;

    alu_issue_wb #(.W(32), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sa(req_sa), .req_sb(req_sb), .req_dst(req_dst),
        .req_gsel(req_gsel), .req_use_const(req_use_const), .req_const(req_const),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gsel(alu_gsel),
        .alu_g(alu_g), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .status(status),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: returns {G, Z, N, C, V}
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] gs);
        logic [32:0] s;
        logic [31:0] bb, g;
        logic        c, v;
        bb = '0; c = 1'b0; v = 1'b0; g = '0;
        if (!gs[3]) begin
            case (gs[2:1])
                2'b00: bb = 32'h0;
                2'b01: bb = b;
                2'b10: bb = ~b;
                default: bb = 32'hFFFF_FFFF;
            endcase
            s = {1'b0, a} + {1'b0, bb} + {32'h0, gs[0]};
            g = s[31:0];
            c = s[32];
            v = (a[31] == bb[31]) && (g[31] != a[31]);
        end else begin
            case (gs[2:1])
                2'b00: g = a & b;
                2'b01: g = a | b;
                2'b10: g = a ^ b;
                default: g = ~a;
            endcase
        end
        return {g, (g == 32'h0), g[31], c, v};
    endfunction

    assign {alu_g, alu_z, alu_n, alu_c, alu_v} = alu_ref(alu_a, alu_b, alu_gsel);

    task automatic do_op(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] dst,
                         input logic [3:0] gs, input logic uc, input logic [31:0] k);
        logic [31:0] ea, eb, eg, old_v;
        logic [3:0]  est;
        logic [35:0] r;
        int          n;
        ea = model_r[sa];
        eb = uc ? k : model_r[sb];
        r  = alu_ref(ea, eb, gs);
        eg = r[35:4];
        est = r[3:0];
        old_v = model_r[dst];
        @(negedge clk);
        req_sa = sa; req_sb = sb; req_dst = dst; req_gsel = gs;
        req_use_const = uc; req_const = k; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++;
        if (alu_a !== ea || alu_b !== eb || alu_gsel !== gs) begin
            n_fail++;
            $display("FAIL operands: a=%h b=%h gsel=%b required a=%h b=%h gsel=%b",
                     alu_a, alu_b, alu_gsel, ea, eb, gs);
        end
        n_cmp++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL exec_cycle: wb_valid=%b req_ready=%b required 0 0", wb_valid, req_ready);
        end
        @(posedge clk); #1;
        dbg_addr = dst; #1;
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_dst !== dst || wb_data !== eg) begin
            n_fail++;
            $display("FAIL wb_pulse: valid=%b dst=%0d data=%h required 1 %0d %h",
                     wb_valid, wb_dst, wb_data, dst, eg);
        end
        n_cmp++;
        if (dbg_data !== old_v) begin
            n_fail++; $display("FAIL no_bypass: dbg_data=%h required %h", dbg_data, old_v);
        end
        @(posedge clk); #1;
        if (dst != 3'd0) model_r[dst] = eg;
        dbg_addr = dst; #1;
        n_cmp++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL after_wb: wb_valid=%b req_ready=%b required 0 1", wb_valid, req_ready);
        end
        n_cmp++;
        if (status !== est || dbg_data !== model_r[dst]) begin
            n_fail++;
            $display("FAIL writeback: R%0d=%h status=%b required %h %b",
                     dst, dbg_data, status, model_r[dst], est);
        end
        $display("op sa=%0d sb=%0d dst=%0d gsel=%b uc=%b k=%h -> g=%h status=%b",
                 sa, sb, dst, gs, uc, k, wb_data, status);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0;
        req_sa = '0; req_sb = '0; req_dst = '0; req_gsel = '0;
        req_use_const = 1'b0; req_const = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++;
        if (req_ready !== 1'b1 || status !== 4'b0000 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b status=%b wb_valid=%b required 1 0000 0",
                     req_ready, status, wb_valid);
        end
        n_cmp++;
        if (alu_a !== '0 || alu_b !== '0 || alu_gsel !== '0 || wb_data !== '0 || wb_dst !== '0) begin
            n_fail++; $display("FAIL reset_regs: a=%h b=%h gsel=%b wb_data=%h required zeros",
                               alu_a, alu_b, alu_gsel, wb_data);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            n_cmp++;
            if (dbg_data !== 32'h0) begin
                n_fail++; $display("FAIL reset_R%0d: %h required 0", i, dbg_data);
            end
        end
        for (int i = 0; i < 8; i++) model_r[i] = '0;
        $display("reset done");
    endtask

    task automatic test_imm_load();
        do_op(3'd0, 3'd0, 3'd1, 4'b0010, 1'b1, 32'h0000_0005);
        dbg_addr = 3'd1; #1;
        n_cmp++;
        if (dbg_data !== 32'h5 || status !== 4'b0000) begin
            n_fail++; $display("FAIL imm_load: R1=%h status=%b required 5 0000", dbg_data, status);
        end
    endtask

    task automatic test_overflow();
        do_op(3'd0, 3'd0, 3'd2, 4'b0010, 1'b1, 32'h7FFF_FFFF);
        do_op(3'd1, 3'd2, 3'd3, 4'b0010, 1'b0, 32'h0);
        dbg_addr = 3'd3; #1;
        n_cmp++;
        if (dbg_data !== 32'h8000_0004 || status !== 4'b0101) begin
            n_fail++; $display("FAIL overflow: R3=%h status=%b required 80000004 0101", dbg_data, status);
        end
    endtask

    task automatic test_sub_zero();
        do_op(3'd1, 3'd1, 3'd4, 4'b0101, 1'b0, 32'h0);
        dbg_addr = 3'd4; #1;
        n_cmp++;
        if (dbg_data !== 32'h0 || status !== 4'b1010) begin
            n_fail++; $display("FAIL sub_zero: R4=%h status=%b required 0 1010", dbg_data, status);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        req_sa = 3'd1; req_sb = 3'd0; req_dst = 3'd0; req_gsel = 4'b1100;
        req_use_const = 1'b1; req_const = 32'hF000_0000; req_valid = 1'b1;
        @(posedge clk); #1;
        // second op offered immediately and held until taken
        req_sa = 3'd3; req_sb = 3'd3; req_dst = 3'd6; req_gsel = 4'b0010; req_use_const = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0 || alu_b !== 32'hF000_0000) begin
            n_fail++; $display("FAIL bp_exec: ready=%b alu_b=%h required 0 f0000000", req_ready, alu_b);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (req_ready !== 1'b0 || wb_valid !== 1'b1 || wb_dst !== 3'd0 || alu_a !== 32'h5) begin
            n_fail++; $display("FAIL bp_wb: ready=%b wb_valid=%b wb_dst=%0d alu_a=%h required 0 1 0 5",
                               req_ready, wb_valid, wb_dst, alu_a);
        end
        @(posedge clk); #1;
        dbg_addr = 3'd0; #1;
        n_cmp++;
        if (status !== 4'b0100 || dbg_data !== 32'h0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first: status=%b R0=%h ready=%b required 0100 0 1",
                               status, dbg_data, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++;
        if (alu_a !== 32'h8000_0004 || alu_b !== 32'h8000_0004) begin
            n_fail++; $display("FAIL bp_second_issue: a=%h b=%h required 80000004 80000004", alu_a, alu_b);
        end
        repeat (2) @(posedge clk);
        #1; dbg_addr = 3'd6; #1;
        model_r[6] = 32'h8;
        n_cmp++;
        if (dbg_data !== 32'h8 || status !== 4'b0011) begin
            n_fail++; $display("FAIL bp_second: R6=%h status=%b required 8 0011", dbg_data, status);
        end
        $display("back-pressure: dst0 op then R6=%h status=%b", dbg_data, status);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_sa = 3'd0; req_sb = 3'd0; req_dst = 3'd5; req_gsel = 4'b0010;
        req_use_const = 1'b1; req_const = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; #1;
        rst = 1'b1; #1;
        n_cmp++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b1 || status !== 4'b0000 || alu_b !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_async: wb_valid=%b ready=%b status=%b alu_b=%h required 0 1 0000 0",
                               wb_valid, req_ready, status, alu_b);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_wb: wb_valid=%b required 0", wb_valid);
            end
        end
        dbg_addr = 3'd5; #1;
        n_cmp++;
        if (dbg_data !== 32'h0 || status !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid_R5: %h status=%b required 0 0000", dbg_data, status);
        end
        dbg_addr = 3'd1; #1;
        n_cmp++;
        if (dbg_data !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_R1: %h required 0", dbg_data);
        end
        for (int i = 0; i < 8; i++) model_r[i] = '0;
        $display("reset mid-op: aborted");
    endtask

    task automatic test_random();
        logic [3:0] ops [9];
        ops = '{4'b0010, 4'b0101, 4'b0001, 4'b1000, 4'b1010, 4'b1100, 4'b1110, 4'b0011, 4'b0110};
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            n_cmp++;
            if (dbg_data !== model_r[i]) begin
                n_fail++; $display("FAIL random_final_R%0d: %h required %h", i, dbg_data, model_r[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_imm_load();
        test_overflow();
        test_sub_zero();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
